// File: rtl/lsu_fetch_monitor.sv
// lsu_fetch_monitor: passive AXI4-lite read monitor producing tracer pulses and load statistics
module lsu_fetch_monitor #(
  parameter int CNT_W = 32,
  parameter int SUM_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ar_valid,
  input  logic             ar_ready,
  input  logic             r_valid,
  input  logic             r_ready,
  input  logic [1:0]       r_resp,
  input  logic             stat_clear,
  output logic             start,
  output logic             finish,
  output logic [CNT_W-1:0] txn_count,
  output logic [SUM_W-1:0] lat_sum,
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] err_count,
  output logic             violation
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d, lat_inc;
  logic             start_q, start_d, finish_q, finish_d, violation_q, violation_d;
  logic [CNT_W-1:0] txn_count_q, txn_count_d, lat_max_q, lat_max_d, err_count_q, err_count_d;
  logic [SUM_W-1:0] lat_sum_q, lat_sum_d;
  logic             ar_hs, r_hs, viol_evt;
  // Handshake decode; lat_inc doubles as the finish-cycle latency (both saturate)
  always_comb begin
    ar_hs   = ar_valid & ar_ready;
    r_hs    = r_valid & r_ready;
    lat_inc = &lat_cnt_q ? lat_cnt_q : lat_cnt_q + CNT_W'(1);
  end
  // Load tracking: next state, latency counter, violation events and pulse requests
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    viol_evt  = 1'b0;
    start_d   = 1'b0;
    finish_d  = 1'b0;
    case (state_q)
      IDLE: begin
        viol_evt = r_hs;
        if (ar_valid) begin
          state_d   = ar_ready ? DATA : ADDR;
          lat_cnt_d = CNT_W'(1);
          start_d   = 1'b1;
        end
      end
      ADDR: begin
        lat_cnt_d = lat_inc;
        viol_evt  = r_hs | ~ar_valid;
        state_d   = !ar_valid ? IDLE : ar_ready ? DATA : ADDR;
      end
      DATA: begin
        lat_cnt_d = lat_inc;
        viol_evt  = ar_hs;
        finish_d  = r_hs;
        state_d   = r_hs ? IDLE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  // Statistics: a clear wins over a same-cycle finish update or new violation
  always_comb begin
    txn_count_d = txn_count_q;
    lat_sum_d   = lat_sum_q;
    lat_max_d   = lat_max_q;
    err_count_d = err_count_q;
    violation_d = violation_q | viol_evt;
    if (stat_clear) begin
      txn_count_d = '0;
      lat_sum_d   = '0;
      lat_max_d   = '0;
      err_count_d = '0;
      violation_d = 1'b0;
    end else if (finish_d) begin
      txn_count_d = txn_count_q + CNT_W'(1);
      lat_sum_d   = lat_sum_q + SUM_W'(lat_inc);
      lat_max_d   = lat_inc > lat_max_q ? lat_inc : lat_max_q;
      err_count_d = err_count_q + CNT_W'(|r_resp);
    end
  end
  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      start_q     <= 1'b0;
      finish_q    <= 1'b0;
      violation_q <= 1'b0;
      txn_count_q <= '0;
      lat_sum_q   <= '0;
      lat_max_q   <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      start_q     <= start_d;
      finish_q    <= finish_d;
      violation_q <= violation_d;
      txn_count_q <= txn_count_d;
      lat_sum_q   <= lat_sum_d;
      lat_max_q   <= lat_max_d;
      err_count_q <= err_count_d;
    end
  end
  assign start     = start_q;
  assign finish    = finish_q;
  assign txn_count = txn_count_q;
  assign lat_sum   = lat_sum_q;
  assign lat_max   = lat_max_q;
  assign err_count = err_count_q;
  assign violation = violation_q;
endmodule

// File: tb/tb_lsu_fetch_monitor.sv
// tb_lsu_fetch_monitor: scoreboard bench with a timestamp-based reference model
module tb_lsu_fetch_monitor;
  logic        clock = 1'b0, reset = 1'b1;
  logic        ar_valid = 1'b0, ar_ready = 1'b0, r_valid = 1'b0, r_ready = 1'b0, stat_clear = 1'b0;
  logic [1:0]  r_resp = 2'b00;
  logic        start, finish, violation;
  logic [7:0]  txn_count, lat_max, err_count;
  logic [15:0] lat_sum;

  lsu_fetch_monitor #(.CNT_W(8), .SUM_W(16)) dut (
    .clock(clock), .reset(reset), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_resp(r_resp), .stat_clear(stat_clear),
    .start(start), .finish(finish), .txn_count(txn_count), .lat_sum(lat_sum),
    .lat_max(lat_max), .err_count(err_count), .violation(violation)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          at;
    logic        s, f, v;
    logic [7:0]  txn, mx, err;
    logic [15:0] sum;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0, edge_n = 0;
  // reference model: load outstanding flag, address-accepted flag, start timestamp
  logic        busy = 1'b0, acc = 1'b0;
  int          t0 = 0;
  logic [7:0]  m_txn = 0, m_max = 0, m_err = 0;
  logic [15:0] m_sum = 0;
  logic        m_viol = 1'b0;

  function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", n, got, exp);
  endfunction

  function automatic void model_step(logic av, logic ar, logic rv, logic rr, logic [1:0] rs, logic clr);
    logic s = 1'b0, f = 1'b0, v = 1'b0;
    int   lat = 0;
    if (!busy) begin
      v = rv & rr;
      if (av) begin busy = 1'b1; acc = ar; t0 = edge_n; s = 1'b1; end
    end else if (!acc) begin
      v = rv & rr;
      if (!av) begin v = 1'b1; busy = 1'b0; end
      else if (ar) acc = 1'b1;
    end else begin
      v = av & ar;
      if (rv & rr) begin
        f = 1'b1; busy = 1'b0;
        lat = edge_n - t0 + 1;
        if (lat > 255) lat = 255;
      end
    end
    if (clr) begin
      m_txn = 0; m_sum = 0; m_max = 0; m_err = 0; m_viol = 1'b0;
    end else begin
      if (f) begin
        m_txn = m_txn + 8'd1;
        m_sum = m_sum + 16'(lat);
        if (lat > int'(m_max)) m_max = 8'(lat);
        if (rs != 2'b00) m_err = m_err + 8'd1;
      end
      if (v) m_viol = 1'b1;
    end
    if (s | f) q.push_back('{at: edge_n + 1, s: s, f: f, v: m_viol, txn: m_txn, mx: m_max, err: m_err, sum: m_sum});
  endfunction

  // monitor: on every pulse (or due expectation) pop the scoreboard and compare
  always @(posedge clock) begin
    exp_t e;
    #1;
    edge_n++;
    if (!reset && (start || finish || (q.size() > 0 && q[0].at == edge_n))) begin
      if (q.size() == 0 || q[0].at != edge_n) chk($sformatf("unexpected_pulse@%0d", edge_n), {start, finish}, 0);
      else begin
        e = q.pop_front();
        chk("sb_start", start, e.s);
        chk("sb_finish", finish, e.f);
        chk("sb_txn", txn_count, e.txn);
        chk("sb_sum", lat_sum, e.sum);
        chk("sb_max", lat_max, e.mx);
        chk("sb_err", err_count, e.err);
        chk("sb_viol", violation, e.v);
      end
    end
  end

  task automatic cyc(input logic av, input logic ar, input logic rv, input logic rr, input logic [1:0] rs, input logic clr);
    ar_valid = av; ar_ready = ar; r_valid = rv; r_ready = rr; r_resp = rs; stat_clear = clr;
    model_step(av, ar, rv, rr, rs, clr);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 2'b00, 0);
  endtask

  task automatic load(input int lat, input logic [1:0] rs);
    cyc(1, 1, 0, 0, 2'b00, 0);
    idle(lat - 2);
    cyc(0, 0, 1, 1, rs, 0);
  endtask

  task automatic chk_stats(input string n, input int t, input int s, input int m, input int e, input logic v);
    chk({n, "_txn"}, txn_count, t);
    chk({n, "_sum"}, lat_sum, s);
    chk({n, "_max"}, lat_max, m);
    chk({n, "_err"}, err_count, e);
    chk({n, "_viol"}, violation, v);
  endtask

  task automatic chk_model(input string n);
    chk_stats(n, m_txn, m_sum, m_max, m_err, m_viol);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ar_valid = 0; ar_ready = 0; r_valid = 0; r_ready = 0; r_resp = 0; stat_clear = 0;
    busy = 1'b0; acc = 1'b0; m_txn = 0; m_sum = 0; m_max = 0; m_err = 0; m_viol = 1'b0;
    q.delete();
    #1;
    chk("rst_pulses", {start, finish}, 0);
    chk_stats("rst", 0, 0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    chk("por_pulses", {start, finish}, 0);
    chk_stats("por", 0, 0, 0, 0, 0);
    reset = 1'b0;
    idle(2);
    load(3, 2'b00);
    chk_stats("single", 1, 3, 3, 0, 0);
    idle(2);
    repeat (4) cyc(1, 0, 0, 0, 2'b00, 0);
    cyc(1, 1, 0, 0, 2'b00, 0);
    idle(4);
    cyc(0, 0, 1, 1, 2'b10, 0);
    chk_stats("addr_wait", 2, 13, 10, 1, 0);
    cyc(0, 0, 0, 0, 2'b00, 1);
    chk_stats("clear1", 0, 0, 0, 0, 0);
    load(2, 2'b00);
    load(5, 2'b00);
    load(3, 2'b00);
    chk_stats("b2b", 3, 10, 5, 0, 0);
    cyc(0, 0, 1, 1, 2'b00, 0);
    idle(1);
    chk_stats("r_in_idle", 3, 10, 5, 0, 1);
    cyc(0, 0, 0, 0, 2'b00, 1);
    chk_stats("clear2", 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 2'b00, 0);
    cyc(0, 0, 0, 0, 2'b00, 0);
    idle(2);
    chk_stats("withdraw", 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 2'b00, 1);
    chk("clear3_viol", violation, 0);
    load(2, 2'b01);
    chk_stats("pre_clr", 1, 2, 2, 1, 0);
    cyc(1, 1, 0, 0, 2'b00, 0);
    idle(2);
    cyc(0, 0, 1, 1, 2'b00, 1);
    chk("clr_fin_pulse", finish, 1);
    chk_stats("clr_fin", 0, 0, 0, 0, 0);
    load(300, 2'b00);
    chk_stats("saturate", 1, 255, 255, 0, 0);
    cyc(1, 1, 0, 0, 2'b00, 0);
    idle(1);
    do_reset();
    load(3, 2'b00);
    chk_stats("post_rst", 1, 3, 3, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      logic av, ar, rv, rr, clr;
      logic [1:0] rs;
      av  = busy ? (acc ? ($urandom % 8 == 0) : ($urandom % 12 != 0)) : ($urandom % 3 == 0);
      ar  = 1'($urandom % 2);
      rv  = (busy && acc) ? 1'($urandom % 2) : ($urandom % 16 == 0);
      rr  = (busy && acc) ? ($urandom % 3 != 0) : ($urandom % 2 == 0);
      rs  = ($urandom % 4 == 0) ? 2'($urandom % 4) : 2'b00;
      clr = ($urandom % 64 == 0);
      cyc(av, ar, rv, rr, rs, clr);
      if (i % 32 == 31) chk_model("rand");
    end
    idle(5);
    chk("queue_drained", q.size(), 0);
    chk_model("final");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
